writeback_buffer: RTL and testbench

- Eviction/write-back buffer directly upstream of MainMemory.
- Accepts dirty-line evictions from the cache controller, queues them, and drains them one per cycle into MainMemory's single addr/wdata/we port.
- Services cache read misses through the same port. Read requests that hit a queued eviction are forwarded from the buffer, so a read never sees stale memory.

---
 rtl/writeback_buffer_if.sv | 47 ++++
 rtl/writeback_buffer.sv | 178 +++++++++++++++++
 tb/tb_writeback_buffer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_buffer_if.sv
// Shared types and the bus bundle for writeback_buffer: the cache-side eviction/read
// ports and the MainMemory port. The optional WB_COALESCE_EN build uses the same bus.
package writeback_buffer_pkg;
    typedef enum logic [1:0] {INV = 2'd0, SHR = 2'd1, EXC = 2'd2, MOD = 2'd3} Tmesi_state;
    typedef struct packed {
        logic       page_reference;
        logic [7:0] address_code;
    } Taddress;
endpackage

interface writeback_buffer_if #(parameter int DATA_W = 64);
    import writeback_buffer_pkg::*;

    logic              evict_valid;
    logic              evict_ready;
    Taddress           evict_addr;
    logic [DATA_W-1:0] evict_data;
    Tmesi_state        evict_mesi;
    logic              rd_req;
    Taddress           rd_addr;
    logic              rd_busy;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    Tmesi_state        rd_mesi;
    logic              drain_en;
    logic              empty;
    Taddress           mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    Tmesi_state        mem_mesi_in;
    logic [DATA_W-1:0] mem_rdata;
    Tmesi_state        mem_mesi_out;

    modport slave (
        input  evict_valid, evict_addr, evict_data, evict_mesi, rd_req, rd_addr,
               drain_en, mem_rdata, mem_mesi_out,
        output evict_ready, rd_busy, rd_valid, rd_data, rd_mesi, empty,
               mem_addr, mem_wdata, mem_we, mem_mesi_in
    );

    modport master (
        output evict_valid, evict_addr, evict_data, evict_mesi, rd_req, rd_addr,
               drain_en, mem_rdata, mem_mesi_out,
        input  evict_ready, rd_busy, rd_valid, rd_data, rd_mesi, empty,
               mem_addr, mem_wdata, mem_we, mem_mesi_in
    );
endinterface

// File: rtl/writeback_buffer.sv
// Eviction queue in front of MainMemory: drains one line per cycle and forwards queued lines to reads.
// Define WB_COALESCE_EN to merge an eviction into an already-queued entry with the same address.
module writeback_buffer
    import writeback_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
) (
    input logic               clk,
    input logic               reset,
    writeback_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} state_t;

    state_t            state_q, state_d;
    Taddress           ent_addr_q [DEPTH];
    Taddress           ent_addr_d [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];
    Tmesi_state        ent_mesi_q [DEPTH];
    Tmesi_state        ent_mesi_d [DEPTH];
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    Tmesi_state        rd_mesi_q, rd_mesi_d;
    Taddress           mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    Tmesi_state        mem_mesi_q, mem_mesi_d;

    logic [AW-1:0]     idx, coal_idx;
    logic              full, ready, drain_go, coal_hit, accept, push, fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    Tmesi_state        fwd_mesi;

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        ent_addr_d  = ent_addr_q;
        ent_data_d  = ent_data_q;
        ent_mesi_d  = ent_mesi_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        rd_mesi_d   = rd_mesi_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_mesi_d  = mem_mesi_q;
        mem_we_d    = 1'b0;
        idx         = '0;
        coal_idx    = '0;
        coal_hit    = 1'b0;
        fwd_hit     = 1'b0;
        fwd_data    = '0;
        fwd_mesi    = INV;

        full     = (count_q == CW'(DEPTH));
        drain_go = (state_q == IDLE) && !bus.rd_req && bus.drain_en && (count_q != '0);
`ifdef WB_COALESCE_EN
        // The head leaving on this edge cannot absorb the write; it gets a fresh slot instead.
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (CW'(i) < count_q && !(drain_go && i == 0) && ent_addr_q[idx] == bus.evict_addr) begin
                coal_hit = 1'b1;
                coal_idx = idx;
            end
        end
`endif
        ready  = !full || coal_hit;
        accept = bus.evict_valid && ready;
        push   = accept && !coal_hit;

        // Scan oldest to youngest so the last match wins; a same-edge eviction is younger still.
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (CW'(i) < count_q && ent_addr_q[idx] == bus.rd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data_q[idx];
                fwd_mesi = ent_mesi_q[idx];
            end
        end
        if (accept && bus.evict_addr == bus.rd_addr) begin
            fwd_hit  = 1'b1;
            fwd_data = bus.evict_data;
            fwd_mesi = bus.evict_mesi;
        end

        case (state_q)
            IDLE: begin
                if (bus.rd_req) begin
                    if (fwd_hit) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = fwd_data;
                        rd_mesi_d  = fwd_mesi;
                    end else begin
                        mem_addr_d = bus.rd_addr;
                        state_d    = RD_ISSUE;
                    end
                end else if (drain_go) begin
                    mem_addr_d  = ent_addr_q[head_q];
                    mem_wdata_d = ent_data_q[head_q];
                    mem_mesi_d  = ent_mesi_q[head_q];
                    mem_we_d    = 1'b1;
                    head_d      = head_q + AW'(1);
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                rd_valid_d = 1'b1;
                rd_data_d  = bus.mem_rdata;
                rd_mesi_d  = bus.mem_mesi_out;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept && coal_hit) begin
            ent_data_d[coal_idx] = bus.evict_data;
            ent_mesi_d[coal_idx] = bus.evict_mesi;
        end else if (push) begin
            ent_addr_d[tail_q] = bus.evict_addr;
            ent_data_d[tail_q] = bus.evict_data;
            ent_mesi_d[tail_q] = bus.evict_mesi;
            tail_d             = tail_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(drain_go);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_mesi_q   <= INV;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_mesi_q  <= INV;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_mesi_q   <= rd_mesi_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_mesi_q  <= mem_mesi_d;
        end
    end

    // Payload storage; validity lives entirely in head/count.
    always_ff @(posedge clk) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
        ent_mesi_q <= ent_mesi_d;
    end

    assign bus.evict_ready = ready;
    assign bus.empty       = (count_q == '0);
    assign bus.rd_busy     = (state_q != IDLE);
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_mesi     = rd_mesi_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_mesi_in = mem_mesi_q;
endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_writeback_buffer;
    import writeback_buffer_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_buffer_if #(.DATA_W(DATA_W)) bus();
    writeback_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    // MainMemory stand-in: write on we, registered read of the sampled address.
    logic [63:0] mem [512];
    Tmesi_state  mem_mesi [512];
    logic [8:0]  mem_a;
    assign mem_a = bus.mem_addr;
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[mem_a]      <= bus.mem_wdata;
            mem_mesi[mem_a] <= bus.mem_mesi_in;
        end
        bus.mem_rdata    <= mem[mem_a];
        bus.mem_mesi_out <= mem_mesi[mem_a];
    end

    // Reference model state
    typedef struct {
        Taddress     addr;
        logic [63:0] data;
        Tmesi_state  mesi;
    } ent_t;
    ent_t        mq[$];
    logic [63:0] ref_mem [512];
    Tmesi_state  ref_mesi [512];
    int          mphase = 0;
    Taddress     mrd_addr;
    logic        x_rvalid = 1'b0, x_we = 1'b0;
    logic [63:0] x_rdata = '0, x_wdata = '0;
    Tmesi_state  x_rmesi = INV, x_mmesi = INV;
    Taddress     x_maddr = '0;

    int ncmp = 0, nfail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit drain_now();
        return (mphase == 0) && !bus.rd_req && bus.drain_en && (mq.size() > 0);
    endfunction

    function automatic int coal_match();
        int r = -1;
`ifdef WB_COALESCE_EN
        for (int i = (drain_now() ? 1 : 0); i < mq.size(); i++)
            if (mq[i].addr == bus.evict_addr) r = i;
`endif
        return r;
    endfunction

    function automatic bit exp_ready();
        return (mq.size() < DEPTH) || (coal_match() >= 0);
    endfunction

    always @(posedge clk) begin : model
        bit dr, acc, hit;
        int ci;
        logic [63:0] hd;
        Tmesi_state hm;
        ent_t e;
        if (reset) begin
            mq.delete();
            mphase = 0;
            x_rvalid = 1'b0; x_rdata = '0; x_rmesi = INV;
            x_we = 1'b0; x_maddr = '0; x_wdata = '0; x_mmesi = INV;
        end else begin
            dr  = drain_now();
            ci  = coal_match();
            acc = bus.evict_valid && ((mq.size() < DEPTH) || ci >= 0);
            x_rvalid = 1'b0;
            x_we     = 1'b0;
            hd = '0; hm = INV; hit = 1'b0;
            if (mphase == 0 && bus.rd_req) begin
                if (acc && bus.evict_addr == bus.rd_addr) begin
                    hit = 1'b1; hd = bus.evict_data; hm = bus.evict_mesi;
                end else begin
                    for (int i = mq.size() - 1; i >= 0; i--)
                        if (!hit && mq[i].addr == bus.rd_addr) begin
                            hit = 1'b1; hd = mq[i].data; hm = mq[i].mesi;
                        end
                end
                if (hit) begin
                    x_rvalid = 1'b1; x_rdata = hd; x_rmesi = hm;
                end else begin
                    mphase = 1; mrd_addr = bus.rd_addr; x_maddr = bus.rd_addr;
                end
            end else if (mphase == 1) begin
                mphase = 2;
            end else if (mphase == 2) begin
                x_rvalid = 1'b1;
                x_rdata  = ref_mem[mrd_addr];
                x_rmesi  = ref_mesi[mrd_addr];
                mphase   = 0;
            end
            if (dr) begin
                e = mq.pop_front();
                x_we = 1'b1; x_maddr = e.addr; x_wdata = e.data; x_mmesi = e.mesi;
                ref_mem[e.addr]  = e.data;
                ref_mesi[e.addr] = e.mesi;
            end
            if (acc) begin
                if (ci >= 0) begin
                    mq[ci - (dr ? 1 : 0)].data = bus.evict_data;
                    mq[ci - (dr ? 1 : 0)].mesi = bus.evict_mesi;
                end else begin
                    e.addr = bus.evict_addr; e.data = bus.evict_data; e.mesi = bus.evict_mesi;
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("evict_ready", bus.evict_ready, exp_ready());
            chk("empty", bus.empty, mq.size() == 0);
            chk("rd_busy", bus.rd_busy, mphase != 0);
            chk("rd_valid", bus.rd_valid, x_rvalid);
            chk("rd_data", bus.rd_data, x_rdata);
            chk("rd_mesi", bus.rd_mesi, x_rmesi);
            chk("mem_we", bus.mem_we, x_we);
            chk("mem_addr", bus.mem_addr, x_maddr);
            chk("mem_wdata", bus.mem_wdata, x_wdata);
            chk("mem_mesi_in", bus.mem_mesi_in, x_mmesi);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic evict(input logic pg, input logic [7:0] a, input logic [63:0] d, input Tmesi_state m);
        bus.evict_valid = 1'b1;
        bus.evict_addr  = '{pg, a};
        bus.evict_data  = d;
        bus.evict_mesi  = m;
    endtask

    task automatic wait_empty(input string nm);
        int k = 0;
        while (!bus.empty && k < 12) begin
            tick();
            k++;
        end
        chk(nm, bus.empty, 1'b1);
    endtask

    logic [63:0] wq[$];

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]      = {32'h0BAD_0000 + 32'(i), 32'h1234_0000 + 32'(i)};
            ref_mem[i]  = mem[i];
            mem_mesi[i] = Tmesi_state'(2'(i));
            ref_mesi[i] = mem_mesi[i];
        end
        mem[9'h005]      = 64'h11223344_55667788;
        ref_mem[9'h005]  = 64'h11223344_55667788;
        mem_mesi[9'h005] = SHR;
        ref_mesi[9'h005] = SHR;

        bus.evict_valid = 1'b0; bus.evict_addr = '0; bus.evict_data = '0; bus.evict_mesi = INV;
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.drain_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_evict_ready", bus.evict_ready, 1'b1);
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_rd_valid", bus.rd_valid, 1'b0);
        chk("rst_rd_mesi", bus.rd_mesi, INV);

        // Fill, hold a fifth eviction, then drain in order
        for (int i = 0; i < 4; i++) begin
            evict(1'b0, 8'h10 + 8'(i), 64'hA0 + 64'(i), MOD);
            tick();
        end
        evict(1'b0, 8'h14, 64'hA4, EXC);
        #1 chk("full_ready", bus.evict_ready, 1'b0);
        tick();
        tick();
        bus.drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_we", bus.mem_we, 1'b1);
            chk("drain_addr", bus.mem_addr, 64'h10 + 64'(i));
            chk("drain_data", bus.mem_wdata, 64'hA0 + 64'(i));
            if (i == 1) bus.evict_valid = 1'b0;
        end
        tick();
        chk("fifth_addr", bus.mem_addr, 64'h14);
        wait_empty("drain_empty");

        // Forward hit
        bus.drain_en = 1'b0;
        evict(1'b1, 8'h20, 64'hDEADBEEF_CAFEF00D, MOD);
        tick();
        bus.evict_valid = 1'b0;
        bus.rd_req = 1'b1; bus.rd_addr = '{1'b1, 8'h20};
        tick();
        bus.rd_req = 1'b0;
        chk("fwd_valid", bus.rd_valid, 1'b1);
        chk("fwd_data", bus.rd_data, 64'hDEADBEEF_CAFEF00D);
        chk("fwd_mesi", bus.rd_mesi, MOD);
        chk("fwd_we", bus.mem_we, 1'b0);

        // Read miss with two entries queued and draining enabled
        evict(1'b0, 8'h21, 64'h5555, SHR);
        tick();
        bus.evict_valid = 1'b0;
        bus.drain_en = 1'b1;
        bus.rd_req = 1'b1; bus.rd_addr = '{1'b0, 8'h05};
        tick();
        bus.rd_req = 1'b0;
        chk("miss_busy", bus.rd_busy, 1'b1);
        tick();
        chk("miss_early", bus.rd_valid, 1'b0);
        tick();
        chk("miss_valid", bus.rd_valid, 1'b1);
        chk("miss_data", bus.rd_data, 64'h11223344_55667788);
        chk("miss_mesi", bus.rd_mesi, SHR);
        tick();
        chk("resume_we", bus.mem_we, 1'b1);
        chk("resume_addr", bus.mem_addr, 64'h120);
        wait_empty("miss_empty");

        // Duplicate address
        bus.drain_en = 1'b0;
        evict(1'b0, 8'h30, 64'd1, SHR);
        tick();
        evict(1'b0, 8'h30, 64'd2, MOD);
        tick();
        bus.evict_valid = 1'b0;
        bus.rd_req = 1'b1; bus.rd_addr = '{1'b0, 8'h30};
        tick();
        bus.rd_req = 1'b0;
        chk("dup_fwd", bus.rd_data, 64'd2);
        bus.drain_en = 1'b1;
        wq.delete();
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.mem_we) wq.push_back(bus.mem_wdata);
        end
`ifdef WB_COALESCE_EN
        chk("dup_writes", 64'(wq.size()), 64'd1);
        if (wq.size() > 0) chk("dup_w0", wq[0], 64'd2);
`else
        chk("dup_writes", 64'(wq.size()), 64'd2);
        if (wq.size() > 1) begin
            chk("dup_w0", wq[0], 64'd1);
            chk("dup_w1", wq[1], 64'd2);
        end
`endif

        // Reset during an outstanding miss
        bus.drain_en = 1'b0;
        evict(1'b0, 8'h40, 64'h77, EXC);
        tick();
        bus.evict_valid = 1'b0;
        bus.rd_req = 1'b1; bus.rd_addr = '{1'b0, 8'h55};
        tick();
        bus.rd_req = 1'b0;
        chk("rr_busy", bus.rd_busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_busy0", bus.rd_busy, 1'b0);
        chk("rr_empty", bus.empty, 1'b1);
        chk("rr_valid", bus.rd_valid, 1'b0);
        tick();
        tick();
        chk("rr_valid_late", bus.rd_valid, 1'b0);

        // Random traffic over a small address set to provoke hits, duplicates and stalls
        for (int c = 0; c < 1500; c++) begin
            reset           = ($urandom_range(0, 199) == 0);
            bus.evict_valid = 1'($urandom_range(0, 1));
            bus.evict_addr  = '{1'($urandom_range(0, 1)), 8'(8'h40 + $urandom_range(0, 5))};
            bus.evict_data  = {$urandom, $urandom};
            bus.evict_mesi  = Tmesi_state'(2'($urandom_range(0, 3)));
            bus.rd_req      = ($urandom_range(0, 3) == 0);
            bus.rd_addr     = '{1'($urandom_range(0, 1)), 8'(8'h40 + $urandom_range(0, 6))};
            bus.drain_en    = ($urandom_range(0, 9) < 7);
            tick();
        end
        reset = 1'b0;
        bus.evict_valid = 1'b0;
        bus.rd_req = 1'b0;
        bus.drain_en = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        wait_empty("final_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
